// File: rtl/booth_mul_arbiter_pkg.sv
// Shared definitions for the booth multiplier arbiter slice.
// Holds the 2-bit FSM state encoding, default sizing constants and a
// helper that derives the requester id width from the requester count.
package booth_mul_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int DEF_N       = 8;
  localparam int DEF_ALPHA   = 3;
  localparam int DEF_R       = 4;
  localparam int DEF_MUL_LAT = DEF_N / 2 + 1;

  // Width needed to encode a requester index (at least one bit).
  function automatic int id_width(input int r);
    return (r <= 1) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/booth_mul_arbiter_booth.sv
// Radix-4 booth multiplier, signed N x N -> 2N, one digit per clock.
// A start pulse loads the operands; N/2 cycles later ans holds the product
// and stays there until the next start. There is no done flag.
// Ports:
//   clk    in  1    clock
//   rst_n  in  1    asynchronous active-low reset
//   start  in  1    load operands and begin
//   m      in  N    signed multiplicand
//   q      in  N    signed multiplier
//   ans    out 2N   signed product
module booth #(
  parameter int N     = 8,
  parameter int alpha = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   m,
  input  logic [N-1:0]   q,
  output logic [2*N-1:0] ans
);

  localparam int STEPS = N / 2;

  logic [2*N-1:0] acc;
  logic [2*N-1:0] mcand;
  logic [N:0]     mplier;
  logic [alpha-1:0] iter;
  logic           run;
  logic [2*N-1:0] pp;

  // Booth digit recoding of the low three multiplier bits into a partial
  // product of 0, +-M or +-2M; mcand is already weighted by 4^iteration.
  always_comb begin
    pp = '0;
    case (mplier[2:0])
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = -(mcand << 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  // Iteration engine: accumulate, shift multiplicand up and multiplier
  // down (arithmetically, so the top digit sees the sign) by two bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      iter   <= '0;
      run    <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {{N{m[N-1]}}, m};
      mplier <= {q, 1'b0};
      iter   <= '0;
      run    <= 1'b1;
    end else if (run) begin
      acc    <= acc + pp;
      mcand  <= mcand << 2;
      mplier <= {{2{mplier[N]}}, mplier[N:2]};
      iter   <= iter + 1'b1;
      if (iter == alpha'(STEPS - 1)) run <= 1'b0;
    end
  end

  assign ans = acc;

endmodule

// File: rtl/booth_mul_arbiter_rr.sv
// Round-robin arbiter (combinational).
// Ports:
//   req   in  R    request vector
//   ptr   in  IDW  highest-priority index for this decision
//   grant out R    one-hot grant (all zero when no request)
//   idx   out IDW  encoded index of the granted requester
//   any   out 1    at least one request present
module rr_arbiter #(
  parameter int R   = 4,
  parameter int IDW = 2
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [R-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  // Walk the requesters starting at ptr and wrapping; the first hit wins.
  always_comb begin
    int i;
    i     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < R; k++) begin
      i = int'(ptr) + k;
      if (i >= R) i = i - R;
      if (!any && req[i]) begin
        any      = 1'b1;
        grant[i] = 1'b1;
        idx      = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one radix-4 booth multiplier between R requesters.
// Round-robin grant in IDLE, one-cycle start pulse, fixed-latency wait
// (the booth core has no done flag), then a registered response held
// until the consumer accepts it.
// Ports:
//   clk_100MHz in  1     system clock
//   rst_n      in  1     asynchronous active-low reset
//   req_valid  in  R     per-requester operand valid
//   req_ready  out R     one-hot accept, only in IDLE
//   req_m      in  R*N   multiplicands, requester i at [i*N +: N]
//   req_q      in  R*N   multipliers, same packing
//   rsp_valid  out 1     result valid
//   rsp_ready  in  1     consumer accepts result
//   rsp_id     out IDW   requester index of the result
//   rsp_ans    out 2N    signed product
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int ALPHA   = DEF_ALPHA,
  parameter int R       = DEF_R,
  parameter int MUL_LAT = N / 2 + 1,
  parameter int IDW     = id_width(R)
) (
  input  logic           clk_100MHz,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_m,
  input  logic [R*N-1:0] req_q,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [2*N-1:0] rsp_ans
);

  localparam int CW = $clog2(MUL_LAT + 1);

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [N-1:0]   op_m, op_q;
  logic [IDW-1:0] op_id;
  logic [CW-1:0]  cnt;
  logic           mul_start;
  logic           accept;
  logic [R-1:0]   grant;
  logic [IDW-1:0] g_idx;
  logic           g_any;
  logic [2*N-1:0] booth_ans;

  rr_arbiter #(.R(R), .IDW(IDW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  booth #(.N(N), .alpha(ALPHA)) u_booth (
    .clk   (clk_100MHz),
    .rst_n (rst_n),
    .start (mul_start),
    .m     (op_m),
    .q     (op_q),
    .ans   (booth_ans)
  );

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and handshake outputs. The grant is masked while reset is
  // held so req_ready reads zero during reset even with requests pending.
  always_comb begin
    state_next = state;
    mul_start  = 1'b0;
    accept     = 1'b0;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (g_any && rst_n) begin
          req_ready  = grant;
          accept     = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        mul_start  = 1'b1;
        state_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (cnt == '0) state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture, pointer advance, latency countdown and response latch.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      op_m    <= '0;
      op_q    <= '0;
      op_id   <= '0;
      cnt     <= '0;
      rsp_id  <= '0;
      rsp_ans <= '0;
    end else begin
      if (accept) begin
        op_m   <= req_m[int'(g_idx)*N +: N];
        op_q   <= req_q[int'(g_idx)*N +: N];
        op_id  <= g_idx;
        rr_ptr <= (g_idx == IDW'(R - 1)) ? '0 : g_idx + 1'b1;
      end
      if (state == ST_START) begin
        cnt <= CW'(MUL_LAT - 1);
      end else if (state == ST_BUSY) begin
        if (cnt == '0) begin
          rsp_ans <= booth_ans;
          rsp_id  <= op_id;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter (N=8, R=4).
// Expected {id, product} pairs go into a scoreboard queue when an accept is
// observed and are popped by a monitor on each response handshake.
module tb_booth_mul_arbiter;

  localparam int N       = 8;
  localparam int R       = 4;
  localparam int IDW     = 2;
  localparam int ALPHA   = 3;
  localparam int MUL_LAT = N / 2 + 1;

  logic           clk_100MHz = 1'b0;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_m;
  logic [R*N-1:0] req_q;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [2*N-1:0] rsp_ans;

  int checks = 0;
  int errors = 0;
  logic [IDW+2*N-1:0] sb[$];

  always #5 clk_100MHz = ~clk_100MHz;

  booth_mul_arbiter #(
    .N(N), .ALPHA(ALPHA), .R(R), .MUL_LAT(MUL_LAT), .IDW(IDW)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_m      (req_m),
    .req_q      (req_q),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_ans    (rsp_ans)
  );

  // Single comparison point: counts every check and reports any failure.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference product, sign-extended to full width before multiplying.
  function automatic logic [15:0] prod(input logic [7:0] m, input logic [7:0] q);
    logic signed [15:0] a, b;
    a = {{8{m[7]}}, m};
    b = {{8{q[7]}}, q};
    return a * b;
  endfunction

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic apply_stimulus(input int id, input logic [7:0] m, input logic [7:0] q);
    req_m[id*N +: N] = m;
    req_q[id*N +: N] = q;
    req_valid[id]    = 1'b1;
  endtask

  // Wait for the scoreboard to empty, then let the final handshake land.
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_100MHz);
      n++;
    end
    check_output("drain", 32'(sb.size()), 32'd0);
    step();
  endtask

  // One isolated operation with latency check; the monitor compares the data.
  task automatic single_op(input int id, input logic [7:0] m, input logic [7:0] q,
                           input logic [15:0] exp_ans);
    apply_stimulus(id, m, q);
    @(negedge clk_100MHz);
    check_output("grant_single", 32'(req_ready), 32'(1) << id);
    sb.push_back({IDW'(id), exp_ans});
    step();
    req_valid = '0;
    for (int j = 1; j <= MUL_LAT + 2; j++) begin
      @(negedge clk_100MHz);
      if (j == MUL_LAT + 1) check_output("latency_early", 32'(rsp_valid), 32'd0);
      if (j == MUL_LAT + 2) check_output("latency_valid", 32'(rsp_valid), 32'd1);
    end
    step();
  endtask

  // Monitor: one-hot accept every cycle, scoreboard pop on each handshake.
  always @(negedge clk_100MHz) begin
    logic [IDW+2*N-1:0] e;
    check_output("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL unexpected_rsp observed id=%0d ans=%h expected no response",
               rsp_id, rsp_ans);
      end else begin
        e = sb.pop_front();
        check_output("rsp_id", 32'(rsp_id), 32'(e[IDW+2*N-1:2*N]));
        check_output("rsp_ans", 32'(rsp_ans), 32'(e[2*N-1:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rr_m [R];
    logic [7:0] rr_q [R];
    int order [5];
    int n;
    rr_m  = '{8'h13, 8'hE5, 8'h7F, 8'h9C};
    rr_q  = '{8'h05, 8'h3A, 8'hF1, 8'h80};
    order = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_m     = '0;
    req_q     = '0;
    rsp_ready = 1'b1;
    #3;
    check_output("reset_ready", 32'(req_ready), 32'd0);
    check_output("reset_valid", 32'(rsp_valid), 32'd0);
    check_output("reset_id", 32'(rsp_id), 32'd0);
    check_output("reset_ans", 32'(rsp_ans), 32'd0);
    repeat (2) @(posedge clk_100MHz);
    #1;
    rst_n = 1'b1;
    step();

    // Directed single operations; pointer walks 0 -> 1 -> 3 -> 2 -> 0.
    single_op(0, 8'h07, 8'hFA, 16'hFFD6);
    single_op(2, 8'h1F, 8'h27, 16'h04B9);
    single_op(1, 8'h80, 8'h80, 16'h4000);
    single_op(3, 8'h7F, 8'h80, 16'hC080);

    // All four requesting continuously: grant order 0,1,2,3,0.
    for (int i = 0; i < R; i++) apply_stimulus(i, rr_m[i], rr_q[i]);
    for (int k = 0; k < 5; k++) begin
      n = 0;
      @(negedge clk_100MHz);
      while (req_ready == '0 && n < 20) begin
        @(negedge clk_100MHz);
        n++;
      end
      check_output("rr_grant", 32'(req_ready), 32'(1) << order[k]);
      sb.push_back({IDW'(order[k]), prod(rr_m[order[k]], rr_q[order[k]])});
      step();
      if (k == 4) req_valid = '0;
    end
    drain();

    // Back-pressure: response held for 10 cycles, no accept meanwhile.
    rsp_ready = 1'b0;
    apply_stimulus(0, 8'h05, 8'hF7);
    @(negedge clk_100MHz);
    check_output("grant_hold", 32'(req_ready), 32'd1);
    sb.push_back({IDW'(0), prod(8'h05, 8'hF7)});
    step();
    req_valid = '0;
    apply_stimulus(1, 8'h0C, 8'h0B);
    n = 0;
    @(negedge clk_100MHz);
    while (!rsp_valid && n < 20) begin
      @(negedge clk_100MHz);
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      check_output("hold_valid", 32'(rsp_valid), 32'd1);
      check_output("hold_ans", 32'(rsp_ans), 32'(prod(8'h05, 8'hF7)));
      check_output("hold_id", 32'(rsp_id), 32'd0);
      check_output("hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk_100MHz);
    end
    @(posedge clk_100MHz);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk_100MHz);
    step();
    @(negedge clk_100MHz);
    check_output("after_hs_valid", 32'(rsp_valid), 32'd0);
    check_output("after_hs_grant", 32'(req_ready), 32'b0010);
    sb.push_back({IDW'(1), 16'h0084});
    step();
    req_valid = '0;
    drain();

    // Reset during BUSY aborts with no response; pointer returns to 0.
    apply_stimulus(2, 8'h33, 8'h44);
    @(negedge clk_100MHz);
    check_output("grant_abort", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check_output("midrst_ready", 32'(req_ready), 32'd0);
    check_output("midrst_valid", 32'(rsp_valid), 32'd0);
    check_output("midrst_id", 32'(rsp_id), 32'd0);
    check_output("midrst_ans", 32'(rsp_ans), 32'd0);
    @(posedge clk_100MHz);
    #1;
    rst_n = 1'b1;
    repeat (12) step();
    check_output("abort_no_rsp", 32'(rsp_valid), 32'd0);
    apply_stimulus(0, 8'h07, 8'hFA);
    apply_stimulus(3, 8'h02, 8'h03);
    @(negedge clk_100MHz);
    check_output("grant_after_rst", 32'(req_ready), 32'b0001);
    sb.push_back({IDW'(0), 16'hFFD6});
    step();
    req_valid = '0;
    drain();

    // A valid pulse only while busy must never be accepted.
    apply_stimulus(0, 8'hF0, 8'h0F);
    @(negedge clk_100MHz);
    check_output("grant_pulse", 32'(req_ready), 32'b0001);
    sb.push_back({IDW'(0), prod(8'hF0, 8'h0F)});
    step();
    req_valid = '0;
    step();
    apply_stimulus(2, 8'h11, 8'h22);
    @(negedge clk_100MHz);
    check_output("pulse_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = '0;
    drain();
    repeat (10) step();
    check_output("pulse_no_rsp", 32'(rsp_valid), 32'd0);
    check_output("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
